// File: rtl/aes_req_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_req_framer_if
// Purpose  : Byte-stream bundle around the AES request framer.
//            s_* : raw bytes from the pins into the framer (valid/ready)
//            m_* : payload bytes from the framer to the core (valid/ready)
// Modports : master - the framer side (accepts s_*, drives m_*)
//            slave  - the environment (drives s_*, accepts m_*)
// Revision : 1.0 - initial release
// ============================================================================
interface aes_req_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid
    );

    modport slave (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid
    );
endinterface
`default_nettype wire

// File: rtl/aes_req_framer.sv
`default_nettype none
// ============================================================================
// Module   : aes_req_framer
// Purpose  : Frames a raw byte stream into one AES request: header byte,
//            three address bytes (MSB first), then an opcode-dependent
//            payload forwarded through a single registered valid/ready stage.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            bus (master)      - s_* byte input, m_* payload output
//            opcode/source_id/dest_id/encdec/addr - header sideband, held
//                                until the next accepted valid header
//            frame_active      - high from header accept until DONE
//            frame_done        - one-cycle pulse, frame complete
//            frame_err         - one-cycle pulse, header rejected
// Revision : 1.0 - initial release
// ============================================================================
module aes_req_framer #(
    parameter int KEY_BYTES   = 32,
    parameter int BLOCK_BYTES = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    aes_req_framer_if.master        bus,
    output logic [1:0]              opcode,
    output logic [1:0]              source_id,
    output logic [1:0]              dest_id,
    output logic                    encdec,
    output logic [23:0]             addr,
    output logic                    frame_active,
    output logic                    frame_done,
    output logic                    frame_err
);

    // Counter sized for the longer of the two payloads so either fits.
    localparam int c_MAX_LEN = (KEY_BYTES > BLOCK_BYTES) ? KEY_BYTES : BLOCK_BYTES;
    localparam int c_CW      = $clog2(c_MAX_LEN + 1);
    localparam logic [c_CW-1:0] c_KEY_LEN   = c_CW'(KEY_BYTES);
    localparam logic [c_CW-1:0] c_BLOCK_LEN = c_CW'(BLOCK_BYTES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR    = 2'd1,
        S_PAYLOAD = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [1:0]        r_addr_cnt;
    logic [7:0]        r_m_data;
    logic              r_m_valid;
    logic [1:0]        r_opcode;
    logic [1:0]        r_source_id;
    logic [1:0]        r_dest_id;
    logic              r_encdec;
    logic [23:0]       r_addr;
    logic              r_active;
    logic              r_done;
    logic              r_err;

    logic [c_CW-1:0]   w_len;
    logic              w_m_free;
    logic              w_s_ready;
    logic              w_xfer;

    always_comb begin
        case (r_opcode)
            2'b00:   w_len = c_KEY_LEN;
            2'b01:   w_len = c_BLOCK_LEN;
            default: w_len = '0;
        endcase
    end

    // Output register is empty now, or is being emptied this cycle.
    assign w_m_free = !r_m_valid || bus.m_ready;

    always_comb begin
        w_s_ready = 1'b0;
        case (r_state)
            S_IDLE:    w_s_ready = 1'b1;
            S_ADDR:    w_s_ready = 1'b1;
            S_PAYLOAD: w_s_ready = (r_cnt < w_len) && w_m_free;
            default:   w_s_ready = 1'b0;
        endcase
        if (rst) begin
            w_s_ready = 1'b0;
        end
    end

    assign w_xfer = bus.s_valid && w_s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr_cnt  <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_opcode    <= '0;
            r_source_id <= '0;
            r_dest_id   <= '0;
            r_encdec    <= 1'b0;
            r_addr      <= '0;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (bus.s_data[7]) begin
                            // Rejected header: sideband keeps prior frame's values.
                            r_err <= 1'b1;
                        end else begin
                            r_opcode    <= bus.s_data[1:0];
                            r_source_id <= bus.s_data[3:2];
                            r_dest_id   <= bus.s_data[5:4];
                            r_encdec    <= bus.s_data[6];
                            r_addr      <= '0;
                            r_cnt       <= '0;
                            r_addr_cnt  <= '0;
                            r_active    <= 1'b1;
                            r_state     <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_xfer) begin
                        r_addr     <= {r_addr[15:0], bus.s_data};
                        r_addr_cnt <= r_addr_cnt + 2'd1;
                        if (r_addr_cnt == 2'd2) begin
                            if (w_len != '0) begin
                                r_state <= S_PAYLOAD;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_xfer) begin
                        r_m_data  <= bus.s_data;
                        r_m_valid <= 1'b1;
                        r_cnt     <= r_cnt + 1'b1;
                    end else if (r_m_valid && bus.m_ready) begin
                        r_m_valid <= 1'b0;
                    end
                    // Leave as the last byte drains so DONE follows the final
                    // m handshake directly instead of one idle cycle later.
                    if ((r_cnt == w_len) && w_m_free) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_active <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready   = w_s_ready;
    assign bus.m_data    = r_m_data;
    assign bus.m_valid   = r_m_valid;
    assign opcode        = r_opcode;
    assign source_id     = r_source_id;
    assign dest_id       = r_dest_id;
    assign encdec        = r_encdec;
    assign addr          = r_addr;
    assign frame_active  = r_active;
    assign frame_done    = r_done;
    assign frame_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_req_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_req_framer
// Purpose  : Self-checking bench for aes_req_framer. A frame-level model
//            (byte position within the frame plus a queue of payload bytes
//            owed to the core) predicts every output each cycle; directed
//            scenarios add literal expectations on timing and counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_req_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  opcode, source_id, dest_id;
    logic        encdec;
    logic [23:0] addr;
    logic        frame_active, frame_done, frame_err;

    aes_req_framer_if bus();

    aes_req_framer #(.KEY_BYTES(32), .BLOCK_BYTES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .opcode       (opcode),
        .source_id    (source_id),
        .dest_id      (dest_id),
        .encdec       (encdec),
        .addr         (addr),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mready_mode = 0;   // 0: held high, 1: toggle, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int len_of(input logic [1:0] op);
        return (op == 2'b00) ? 32 : (op == 2'b01) ? 16 : 0;
    endfunction

    // ---------------- behavioural model ----------------
    bit          e_active = 0, e_in_done = 0, e_done = 0, e_err = 0;
    int          e_pos = 0;        // bytes of the current frame accepted so far
    int          e_len = 0;
    logic [1:0]  e_op = 0, e_src = 0, e_dst = 0;
    logic        e_enc = 0;
    logic [23:0] e_addr = 0;
    logic [7:0]  e_q[$];           // payload bytes owed to the core
    bit          exp_sr;

    int hdr_cyc = 0, done_cyc = 0, done_cnt = 0, err_cnt = 0, mhs_cnt = 0;
    int mv_run = 0, mv_max = 0;

    always @(negedge clk) begin
        bit xfer, mhs;
        if (rst)                          exp_sr = 0;
        else if (e_in_done)               exp_sr = 0;
        else if (!e_active || e_pos < 4)  exp_sr = 1;
        else exp_sr = (e_pos - 4 < e_len) && (e_q.size() == 0 || bus.m_ready);

        check("s_ready", 32'(bus.s_ready), 32'(exp_sr));
        check("m_valid", 32'(bus.m_valid), 32'(e_q.size() > 0));
        if (e_q.size() > 0) check("m_data", 32'(bus.m_data), 32'(e_q[0]));
        check("frame_done", 32'(frame_done), 32'(e_done));
        check("frame_err", 32'(frame_err), 32'(e_err));
        check("frame_active", 32'(frame_active), 32'(e_active));
        check("opcode", 32'(opcode), 32'(e_op));
        check("source_id", 32'(source_id), 32'(e_src));
        check("dest_id", 32'(dest_id), 32'(e_dst));
        check("encdec", 32'(encdec), 32'(e_enc));
        check("addr", 32'(addr), 32'(e_addr));

        if (frame_done) begin done_cnt++; done_cyc = cyc; end
        if (frame_err) err_cnt++;
        if (bus.m_valid && bus.m_ready) mhs_cnt++;
        if (bus.m_valid) begin mv_run++; if (mv_run > mv_max) mv_max = mv_run; end
        else mv_run = 0;

        // advance the model to the next cycle
        xfer = bus.s_valid && exp_sr;
        mhs  = (e_q.size() > 0) && bus.m_ready;
        if (rst) begin
            e_active = 0; e_in_done = 0; e_done = 0; e_err = 0; e_pos = 0;
            e_op = 0; e_src = 0; e_dst = 0; e_enc = 0; e_addr = 0; e_q.delete();
        end else begin
            e_done = 0; e_err = 0;
            if (e_in_done) begin
                e_in_done = 0; e_active = 0;
            end else if (!e_active) begin
                if (xfer) begin
                    if (bus.s_data[7]) e_err = 1;
                    else begin
                        e_op = bus.s_data[1:0]; e_src = bus.s_data[3:2];
                        e_dst = bus.s_data[5:4]; e_enc = bus.s_data[6];
                        e_addr = 0; e_active = 1; e_pos = 1; e_len = len_of(bus.s_data[1:0]);
                        hdr_cyc = cyc;
                    end
                end
            end else if (e_pos < 4) begin
                if (xfer) begin
                    e_addr = {e_addr[15:0], bus.s_data};
                    e_pos++;
                    if (e_pos == 4 && e_len == 0) begin e_in_done = 1; e_done = 1; end
                end
            end else begin
                if (mhs) void'(e_q.pop_front());
                if (xfer) begin e_q.push_back(bus.s_data); e_pos++; end
                if (e_pos - 4 == e_len && e_q.size() == 0) begin e_in_done = 1; e_done = 1; end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (mready_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = ~bus.m_ready;
                default: bus.m_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        bit ok;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin @(posedge clk); #1; end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); ok = bus.s_ready;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=no_accept required=accept byte=%0h", b);
        end
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [23:0] a,
                              input int gap, input bit seq);
        send_byte(hdr, gap);
        if (!hdr[7]) begin
            send_byte(a[23:16], gap);
            send_byte(a[15:8], gap);
            send_byte(a[7:0], gap);
            for (int i = 0; i < len_of(hdr[1:0]); i++)
                send_byte(seq ? 8'(i) : 8'($urandom), gap);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clk); #1;
            ok = !e_active;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    initial begin
        int d0, e0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_opcode", 32'(opcode), 32'h0);
        check("reset_addr", 32'(addr), 32'h0);
        check("reset_m_data", 32'(bus.m_data), 32'h0);
        check("reset_active", 32'(frame_active), 32'h0);

        // Text load, back-to-back, m_ready high
        mready_mode = 0;
        @(posedge clk); #1;
        mv_max = 0;
        send_frame(8'h55, 24'h123456, 0, 1);
        wait_idle();
        check("text_addr", 32'(addr), 32'h123456);
        check("text_opcode", 32'(opcode), 32'h1);
        check("text_src_dst_enc", 32'({source_id, dest_id, encdec}), 32'b01_01_1);
        check("text_frame_cycles", 32'(done_cyc - hdr_cyc + 1), 32'd22);
        check("text_no_bubble", 32'(mv_max), 32'd16);

        // Key load with m_ready toggling
        mready_mode = 1;
        mhs_cnt = 0;
        send_frame(8'h00, 24'hABCDEF, 0, 0);
        wait_idle();
        check("key_handshakes", 32'(mhs_cnt), 32'd32);

        // Zero-length opcode
        mready_mode = 0;
        mhs_cnt = 0;
        send_frame(8'h02, 24'h000001, 0, 0);
        wait_idle();
        check("zero_done_latency", 32'(done_cyc - hdr_cyc), 32'd4);
        check("zero_no_payload", 32'(mhs_cnt), 32'd0);
        check("zero_addr", 32'(addr), 32'h000001);

        // Bad header then good header
        e0 = err_cnt;
        send_byte(8'h80, 0);
        repeat (2) begin @(posedge clk); #1; end
        check("bad_err_pulse", 32'(err_cnt - e0), 32'd1);
        check("bad_opcode_held", 32'(opcode), 32'h2);
        send_frame(8'h01, 24'h000102, 0, 1);
        wait_idle();
        check("good_after_bad_opcode", 32'(opcode), 32'h1);

        // Reset after 5 of 16 payload bytes
        d0 = done_cnt;
        send_byte(8'h01, 0);
        for (int i = 0; i < 3; i++) send_byte(8'(i), 0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_active", 32'(frame_active), 32'h0);
        check("rst_m_valid", 32'(bus.m_valid), 32'h0);
        repeat (4) begin @(posedge clk); #1; end
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        send_frame(8'h55, 24'h654321, 0, 1);
        wait_idle();
        check("rst_then_clean_done", 32'(done_cnt - d0), 32'd1);

        // Randomized frames, gaps and backpressure
        mready_mode = 2;
        for (int f = 0; f < 20; f++) begin
            logic [7:0] h;
            h = 8'($urandom);
            h[7] = ($urandom_range(5, 0) == 0);
            send_frame(h, 24'($urandom), 3, 0);
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
